sram_max_reducer: RTL

//  Controller that sits on the read/write ports of the dual-read SRAM. It runs an
//  in-place pairwise signed-max tree reduction over N = 2**LOG_N words starting at

---
 rtl/max_reducer_pkg.sv | 18 +
 rtl/max_cmp2.sv | 26 ++
 rtl/sram_max_reducer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/max_reducer_pkg.sv
// rtl/max_reducer_pkg.sv - FSM state codes, drain length and pair-count helper for sram_max_reducer
package max_reducer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_READ  = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  // Covers the 2-cycle read-to-write pipeline plus the SRAM's 1-cycle write commit
  localparam int unsigned DRAIN_CYCLES = 3;

  function automatic int unsigned pair_count(input int unsigned log_n, input int unsigned level);
    return (32'd1 << log_n) >> (level + 1);
  endfunction

endpackage

// File: rtl/max_cmp2.sv
// rtl/max_cmp2.sv - signed two-word max select, ties to operand a; index select under MAX_REDUCER_ARGMAX_EN
module max_cmp2 #(
  parameter int DATA_WIDTH = 32
`ifdef MAX_REDUCER_ARGMAX_EN
  , parameter int IDX_WIDTH = 4
`endif
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
`ifdef MAX_REDUCER_ARGMAX_EN
  input  logic        [IDX_WIDTH-1:0]  idx_a,
  input  logic        [IDX_WIDTH-1:0]  idx_b,
  output logic        [IDX_WIDTH-1:0]  idx_max,
`endif
  output logic signed [DATA_WIDTH-1:0] max_val
);

  logic take_a;

  assign take_a  = (a >= b);
  assign max_val = take_a ? a : b;
`ifdef MAX_REDUCER_ARGMAX_EN
  assign idx_max = take_a ? idx_a : idx_b;
`endif

endmodule

// File: rtl/sram_max_reducer.sv
// rtl/sram_max_reducer.sv - in-place pairwise signed-max tree reduction over a dual-read SRAM
// Optional argmax tracking is enabled by defining MAX_REDUCER_ARGMAX_EN.
module sram_max_reducer
  import max_reducer_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int LOG_N      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic        [ADDR_WIDTH-1:0] base_addr,
  output logic                         busy,
  output logic                         done,
  output logic signed [DATA_WIDTH-1:0] max_out,
  output logic        [LOG_N-1:0]      max_idx,
  output logic        [ADDR_WIDTH-1:0] raddr_a,
  output logic        [ADDR_WIDTH-1:0] raddr_b,
  input  logic signed [DATA_WIDTH-1:0] dout_a,
  input  logic signed [DATA_WIDTH-1:0] dout_b,
  output logic        [ADDR_WIDTH-1:0] waddr,
  output logic signed [DATA_WIDTH-1:0] din,
  output logic                         write
);

  localparam int LVL_W = (LOG_N > 1) ? $clog2(LOG_N) : 1;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [LVL_W-1:0]        level_q;
  logic [LOG_N-1:0]        pair_q;
  logic [LOG_N-1:0]        last_pair;
  logic [1:0]              drain_q;
  logic                    last_level;
  logic                    drain_end;

  logic                    rd_v;
  logic                    rd_last;
  logic [ADDR_WIDTH-1:0]   rd_waddr;
  logic signed [DATA_WIDTH-1:0] sel_val;

  assign last_pair  = LOG_N'(pair_count(LOG_N, 32'(level_q)) - 1);
  assign last_level = (level_q == LVL_W'(LOG_N - 1));
  assign drain_end  = (drain_q == 2'(DRAIN_CYCLES - 1));

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign raddr_a = busy ? base_q + ADDR_WIDTH'({pair_q, 1'b0}) : '0;
  assign raddr_b = busy ? base_q + ADDR_WIDTH'({pair_q, 1'b1}) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      level_q <= '0;
      pair_q  <= '0;
      drain_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_READ;
            base_q  <= base_addr;
            level_q <= '0;
            pair_q  <= '0;
          end
        end
        S_READ: begin
          if (pair_q == last_pair) begin
            state_q <= S_DRAIN;
            pair_q  <= '0;
            drain_q <= '0;
          end else begin
            pair_q <= pair_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_end) begin
            if (last_level) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_READ;
              level_q <= level_q + 1'b1;
            end
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MAX_REDUCER_ARGMAX_EN
  localparam int N_HALF = (1 << LOG_N) / 2;
  localparam int PW     = (LOG_N > 1) ? LOG_N - 1 : 1;

  logic [LOG_N-1:0] idx_mem [N_HALF];
  logic [LOG_N-1:0] rd_pair;
  logic             rd_lvl0;
  logic [LOG_N-1:0] ev_idx, od_idx;
  logic [LOG_N-1:0] idx_a, idx_b, sel_idx;
  logic [LOG_N-1:0] max_idx_q;

  // Level 0 operands carry their own element index; later levels read survivors
  assign ev_idx = LOG_N'({rd_pair, 1'b0});
  assign od_idx = LOG_N'({rd_pair, 1'b1});
  assign idx_a  = rd_lvl0 ? ev_idx : idx_mem[ev_idx[PW-1:0]];
  assign idx_b  = rd_lvl0 ? od_idx : idx_mem[od_idx[PW-1:0]];
  assign max_idx = max_idx_q;

  always_ff @(posedge clk) begin
    if (rd_v) begin
      idx_mem[rd_pair[PW-1:0]] <= sel_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pair   <= '0;
      rd_lvl0   <= 1'b0;
      max_idx_q <= '0;
    end else begin
      rd_pair <= pair_q;
      rd_lvl0 <= (level_q == '0);
      if (rd_v && rd_last) begin
        max_idx_q <= sel_idx;
      end
    end
  end
`else
  assign max_idx = '0;
`endif

  max_cmp2 #(
    .DATA_WIDTH (DATA_WIDTH)
`ifdef MAX_REDUCER_ARGMAX_EN
    , .IDX_WIDTH (LOG_N)
`endif
  ) u_cmp (
    .a       (dout_a),
    .b       (dout_b),
`ifdef MAX_REDUCER_ARGMAX_EN
    .idx_a   (idx_a),
    .idx_b   (idx_b),
    .idx_max (sel_idx),
`endif
    .max_val (sel_val)
  );

  // Stage 1 tracks the read issued last cycle; stage 2 registers the write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v     <= 1'b0;
      rd_last  <= 1'b0;
      rd_waddr <= '0;
      write    <= 1'b0;
      waddr    <= '0;
      din      <= '0;
      max_out  <= '0;
    end else begin
      rd_v     <= (state_q == S_READ);
      rd_last  <= last_level;
      rd_waddr <= base_q + ADDR_WIDTH'(pair_q);
      write    <= rd_v;
      if (rd_v) begin
        waddr <= rd_waddr;
        din   <= sel_val;
      end
      if (rd_v && rd_last) begin
        max_out <= sel_val;
      end
    end
  end

endmodule
